// File: rtl/torpedo_scheduler.sv
// Torpedo launch scheduler: turns fire-button edges into one-hot launch requests
// to free torpedo slots, with round-robin slot choice, ack timeout and frame cooldown.
module torpedo_scheduler #(
  parameter int T_NUM       = 4,
  parameter int COOLDOWN    = 6,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic             vsync,
  input  logic             enable,
  input  logic             fire,
  input  logic [T_NUM-1:0] slot_busy,
  output logic [T_NUM-1:0] launch,
  output logic             launching,
  output logic             dry,
  output logic [15:0]      shots
);

  localparam int PW = $clog2(T_NUM);

  typedef enum logic [1:0] {IDLE, LAUNCH, COOL} state_t;

  state_t           state_q, state_d;
  logic             fire_d_q;
  logic             pending_q, pending_d;
  logic [PW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [PW-1:0]    sel_q, sel_d;
  logic [7:0]       cool_cnt_q, cool_cnt_d;
  logic [7:0]       timeout_q, timeout_d;
  logic [T_NUM-1:0] launch_q, launch_d;
  logic [15:0]      shots_q, shots_d;
  logic             fire_edge;
  logic             ack;
  logic [PW-1:0]    free_sel;

  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
    return (int'(p) == T_NUM - 1) ? '0 : p + 1'b1;
  endfunction

  // First free slot at or after ptr, wrapping; only used when some slot is free.
  function automatic logic [PW-1:0] first_free(input logic [PW-1:0] ptr,
                                               input logic [T_NUM-1:0] busy);
    logic [PW-1:0] idx;
    logic [PW-1:0] pick;
    logic          found;
    idx   = ptr;
    pick  = ptr;
    found = 1'b0;
    for (int k = 0; k < T_NUM; k++) begin
      if (!found && !busy[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
      idx = wrap_inc(idx);
    end
    return pick;
  endfunction

  function automatic logic [T_NUM-1:0] onehot(input logic [PW-1:0] s);
    logic [T_NUM-1:0] oh;
    oh    = '0;
    oh[s] = 1'b1;
    return oh;
  endfunction

  assign fire_edge = fire & ~fire_d_q & enable;
  assign ack       = slot_busy[sel_q];
  assign free_sel  = first_free(rr_ptr_q, slot_busy);

  always_comb begin
    // NOTE: every next-state signal gets a default first so no path leaves it unassigned (no latches).
    state_d    = state_q;
    pending_d  = pending_q;
    rr_ptr_d   = rr_ptr_q;
    sel_d      = sel_q;
    cool_cnt_d = cool_cnt_q;
    timeout_d  = timeout_q;
    launch_d   = '0;
    shots_d    = shots_q;

    if (!enable) begin
      state_d    = IDLE;
      pending_d  = 1'b0;
      cool_cnt_d = '0;
      timeout_d  = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (pending_q && !(&slot_busy)) begin
            sel_d     = free_sel;
            pending_d = 1'b0;
            timeout_d = 8'(ACK_TIMEOUT);
            launch_d  = onehot(free_sel);
            state_d   = LAUNCH;
          end else if (fire_edge) begin
            pending_d = 1'b1;
          end
        end
        LAUNCH: begin
          if (ack) begin
            shots_d    = (shots_q == 16'hFFFF) ? shots_q : shots_q + 16'd1;
            rr_ptr_d   = wrap_inc(sel_q);
            cool_cnt_d = 8'(COOLDOWN);
            timeout_d  = '0;
            state_d    = COOL;
          end else begin
            timeout_d = timeout_q - 8'd1;
            if (timeout_q == 8'd1) begin
              // Give up on a slot that never answers and move past it.
              rr_ptr_d = wrap_inc(sel_q);
              state_d  = IDLE;
            end else begin
              launch_d = launch_q;
            end
          end
        end
        COOL: begin
          if (cool_cnt_q == 8'd0) begin
            pending_d = fire;
            state_d   = IDLE;
          end else if (vsync) begin
            cool_cnt_d = cool_cnt_q - 8'd1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q    <= IDLE;
      // A button held across reset release must not count as a press.
      fire_d_q   <= 1'b1;
      pending_q  <= 1'b0;
      rr_ptr_q   <= '0;
      sel_q      <= '0;
      cool_cnt_q <= '0;
      timeout_q  <= '0;
      launch_q   <= '0;
      shots_q    <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge values.
      state_q    <= state_d;
      fire_d_q   <= fire;
      pending_q  <= pending_d;
      rr_ptr_q   <= rr_ptr_d;
      sel_q      <= sel_d;
      cool_cnt_q <= cool_cnt_d;
      timeout_q  <= timeout_d;
      launch_q   <= launch_d;
      shots_q    <= shots_d;
    end
  end

  assign launch    = launch_q;
  assign launching = (state_q != IDLE);
  assign dry       = (state_q == IDLE) & pending_q & (&slot_busy);
  assign shots     = shots_q;

endmodule

// File: tb/tb_torpedo_scheduler.sv
// Directed self-checking bench for torpedo_scheduler with default parameters
// (4 slots, cooldown 6 frames, ack timeout 15 cycles).
module tb_torpedo_scheduler;

  logic        clk;
  logic        resetN;
  logic        vsync;
  logic        enable;
  logic        fire;
  logic [3:0]  slot_busy;
  logic [3:0]  launch;
  logic        launching;
  logic        dry;
  logic [15:0] shots;

  int n_checks;
  int n_errors;
  int n_high;
  int rise_n;
  int frame;
  logic [3:0] prev_launch;

  torpedo_scheduler #(
    .T_NUM      (4),
    .COOLDOWN   (6),
    .ACK_TIMEOUT(15)
  ) dut (
    .clk      (clk),
    .resetN   (resetN),
    .vsync    (vsync),
    .enable   (enable),
    .fire     (fire),
    .slot_busy(slot_busy),
    .launch   (launch),
    .launching(launching),
    .dry      (dry),
    .shots    (shots)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Each frame: vsync high for one sampled edge, then two quiet cycles.
  task automatic frames(input int n);
    repeat (n) begin
      vsync = 1'b1;
      cyc(1);
      vsync = 1'b0;
      cyc(2);
    end
  endtask

  // Fire pulse: edge sampled on the first clock, launch visible after the second.
  task automatic press();
    fire = 1'b1;
    cyc(1);
    fire = 1'b0;
    cyc(1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    resetN    = 1'b0;
    vsync     = 1'b0;
    enable    = 1'b1;
    fire      = 1'b1;
    slot_busy = 4'b0000;

    // Reset values, with fire held through release.
    #2;
    check("rst_launch", launch, 4'b0000);
    check("rst_launching", launching, 1'b0);
    check("rst_dry", dry, 1'b0);
    check("rst_shots", shots, 16'd0);
    #21 resetN = 1'b1;
    cyc(4);
    check("held_fire_no_shot", launching, 1'b0);
    check("held_fire_launch", launch, 4'b0000);
    fire = 1'b0;
    cyc(1);

    // Basic launch, latency, ack after 4 launch cycles, cooldown, rotation.
    fire = 1'b1;
    cyc(1);
    check("lat_not_yet", launch, 4'b0000);
    fire = 1'b0;
    cyc(1);
    check("lat_launch", launch, 4'b0001);
    for (int k = 0; k < 3; k++) begin
      cyc(1);
      check("launch_hold", launch, 4'b0001);
    end
    slot_busy = 4'b0001;
    cyc(1);
    check("ack_drop", launch, 4'b0000);
    check("ack_shots1", shots, 16'd1);
    check("ack_cool", launching, 1'b1);
    slot_busy = 4'b0000;
    frames(5);
    check("cool_5f", launching, 1'b1);
    frames(1);
    check("cool_done", launching, 1'b0);
    press();
    check("second_slot", launch, 4'b0010);
    slot_busy = 4'b0010;
    cyc(1);
    check("ack_shots2", shots, 16'd2);
    slot_busy = 4'b0000;
    frames(6);

    // All slots busy: request waits as dry, then takes the slot that frees up.
    slot_busy = 4'b1111;
    fire = 1'b1;
    cyc(1);
    fire = 1'b0;
    check("dry_set", dry, 1'b1);
    cyc(3);
    check("dry_persist", dry, 1'b1);
    check("dry_no_launch", launch, 4'b0000);
    slot_busy = 4'b1011;
    #1;
    check("dry_clear", dry, 1'b0);
    cyc(1);
    check("dry_launch", launch, 4'b0100);
    cyc(1);
    check("other_busy_ignored", launch, 4'b0100);
    slot_busy = 4'b1111;
    cyc(1);
    check("ack_shots3", shots, 16'd3);
    slot_busy = 4'b0000;
    frames(6);

    // Stuck slot: launch lasts exactly 15 cycles, no shot, next slot is used.
    press();
    check("stuck_slot", launch, 4'b1000);
    n_high = 1;
    for (int k = 0; k < 40; k++) begin
      cyc(1);
      if (launch == 4'b0000) break;
      n_high++;
    end
    check("timeout_len", n_high, 15);
    check("timeout_shots", shots, 16'd3);
    check("timeout_idle", launching, 1'b0);
    press();
    check("after_stuck_slot", launch, 4'b0001);
    slot_busy = 4'b0001;
    cyc(1);
    check("ack_shots4", shots, 16'd4);
    slot_busy = 4'b0000;
    frames(6);

    // Enable drops during cooldown with fire held.
    fire = 1'b1;
    cyc(2);
    check("en_launch", launch, 4'b0010);
    slot_busy = 4'b0010;
    cyc(1);
    slot_busy = 4'b0000;
    frames(2);
    check("en_in_cool", launching, 1'b1);
    enable = 1'b0;
    cyc(1);
    check("en_off_idle", launching, 1'b0);
    cyc(3);
    enable = 1'b1;
    cyc(10);
    check("en_no_relaunch", launching, 1'b0);
    check("en_shots", shots, 16'd5);
    fire = 1'b0;
    cyc(1);
    press();
    check("en_new_edge", launch, 4'b0100);
    slot_busy = 4'b0100;
    cyc(1);
    check("ack_shots6", shots, 16'd6);
    slot_busy = 4'b0000;
    frames(6);

    // Reset asserted in the middle of a launch.
    press();
    check("pre_rst_launch", launch, 4'b1000);
    #3 resetN = 1'b0;
    #1;
    check("mid_rst_launch", launch, 4'b0000);
    check("mid_rst_shots", shots, 16'd0);
    check("mid_rst_launching", launching, 1'b0);
    #10 resetN = 1'b1;
    cyc(2);

    // Auto-repeat: fire held for 30 three-cycle frames, immediate acks
    // that coincide with vsync.
    rise_n      = 0;
    frame       = 0;
    prev_launch = 4'b0000;
    for (int i = 0; i < 90; i++) begin
      slot_busy = launch;
      vsync     = (i % 3 == 2);
      fire      = 1'b1;
      @(posedge clk);
      #1;
      if (launch != 4'b0000 && prev_launch == 4'b0000) begin
        if (rise_n < 5) begin
          check("rpt_frame", frame, rise_n * 7);
          check("rpt_slot", launch, 32'(1) << (rise_n % 4));
        end
        rise_n++;
      end
      if (vsync) frame++;
      prev_launch = launch;
    end
    fire      = 1'b0;
    vsync     = 1'b0;
    slot_busy = 4'b0000;
    check("rpt_count", rise_n, 5);
    check("rpt_shots", shots, 16'd5);
    frames(6);
    check("rpt_idle", launching, 1'b0);

    // Saturation: counter preset just below the top, then two acked launches.
    force dut.shots_q = 16'hFFFE;
    cyc(1);
    release dut.shots_q;
    press();
    check("sat_slot1", launch, 4'b0010);
    slot_busy = 4'b0010;
    cyc(1);
    check("sat_first", shots, 16'hFFFF);
    slot_busy = 4'b0000;
    frames(6);
    press();
    check("sat_slot2", launch, 4'b0100);
    slot_busy = 4'b0100;
    cyc(1);
    check("sat_second", shots, 16'hFFFF);
    slot_busy = 4'b0000;
    cyc(2);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/torpedo_scheduler.md
TORPEDO_SCHEDULER -- requirements
Module: torpedo_scheduler

Interface
REQ-001 The block SHALL have parameter T_NUM, default 4, giving the number of torpedo slots (2..8).
REQ-002 The block SHALL have parameter COOLDOWN, default 6, giving the minimum number of frames between launches (0..255).
REQ-003 The block SHALL have parameter ACK_TIMEOUT, default 15, giving the maximum number of clk cycles to wait for slot acknowledge (1..255).
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock (clk_25 domain).
REQ-005 The block SHALL have port resetN, input, 1 bit: asynchronous active-low reset.
REQ-006 The block SHALL have port vsync, input, 1 bit: single-cycle frame pulse.
REQ-007 The block SHALL have port enable, input, 1 bit: game active (high outside opening screen and game over).
REQ-008 The block SHALL have port fire, input, 1 bit: fire button level.
REQ-009 The block SHALL have port slot_busy, input, T_NUM bits: per-slot torpedo flying.
REQ-010 The block SHALL have port launch, output, T_NUM bits: one-hot launch request to a slot.
REQ-011 The block SHALL have port launching, output, 1 bit: high whenever the state is not IDLE.
REQ-012 The block SHALL have port dry, output, 1 bit: a request is pending while all slots are busy.
REQ-013 The block SHALL have port shots, output, 16 bits: count of acknowledged launches.

Function
REQ-014 The block SHALL register fire into fire_d every cycle; an edge is fire & ~fire_d & enable.
REQ-015 An edge SHALL set pending only in IDLE; edges seen in LAUNCH or COOL SHALL be discarded, not queued.
REQ-016 The FSM SHALL have the states IDLE, LAUNCH and COOL.
REQ-017 In IDLE with pending=1, enable=1 and any bit of slot_busy low, the block SHALL:
- select sel, the first free slot scanning from rr_ptr upward with wrap;
- clear pending;
- load the timeout counter with ACK_TIMEOUT;
- go to LAUNCH.
REQ-018 launch SHALL be a registered output equal to onehot(sel) in every LAUNCH cycle and all-zero in every other state.
REQ-019 In LAUNCH, slot_busy[sel]=1 SHALL be the acknowledge. On acknowledge the block SHALL:
- increment shots, saturating at 16'hFFFF;
- set rr_ptr to (sel+1) mod T_NUM;
- load cool_cnt with COOLDOWN;
- go to COOL.
REQ-020 In LAUNCH with no acknowledge, the timeout counter SHALL decrement each cycle. At 0 the block SHALL go to IDLE with shots unchanged and rr_ptr set to (sel+1) mod T_NUM, so a stuck slot is skipped.
REQ-021 In COOL, cool_cnt SHALL decrement on each vsync. When cool_cnt==0 the block SHALL go to IDLE, and SHALL set pending if fire=1 in that cycle (auto-repeat). With COOLDOWN=0, COOL SHALL last exactly one cycle.
REQ-022 dry SHALL equal (state==IDLE) & pending & (&slot_busy). Pending SHALL persist while all slots are busy.
REQ-023 enable=0 SHALL force the next state to IDLE and clear pending, launch, cool_cnt and the timeout counter; rr_ptr and shots SHALL be held.
REQ-024 When vsync and acknowledge coincide, the acknowledge SHALL be processed and vsync SHALL NOT decrement the freshly loaded cool_cnt.
REQ-025 Latency: launch SHALL rise 2 cycles after the first clk edge that samples the fire edge (edge sampled at N, pending at N+1, launch at N+2).
REQ-026 slot_busy bits other than sel SHALL NOT affect the LAUNCH state.

Reset
REQ-027 While resetN=0 the block SHALL hold: state=IDLE, launch=0, launching=0, dry=0, shots=0, pending=0, rr_ptr=0, cool_cnt=0, timeout=0.
REQ-028 fire_d SHALL reset to 1, so a button held through reset release (resetN=~Start) produces no shot.
REQ-029 Reset asserted mid-LAUNCH SHALL drop launch asynchronously without incrementing shots.

Verification
REQ-030 All slots free, fire pulse, ack after 3 cycles -> launch=4'b0001 for 4 cycles, shots=1, rr_ptr=1; a second pulse after cooldown -> launch=4'b0010.
REQ-031 fire held for 30 frames, COOLDOWN=6, immediate acks -> launches at frames 0,7,14,21,28 (5 shots) rotating slots 0,1,2,3,0.
REQ-032 slot_busy=4'b1111, fire pulse -> dry=1 and no launch; slot_busy becomes 4'b1011 -> launch=4'b0100 within 2 cycles, dry=0.
REQ-033 Slot never acks -> launch drops after exactly 15 cycles, shots unchanged, next request targets the following slot.
REQ-034 enable falls during COOL with fire held -> IDLE next cycle, no further launches until a new edge after enable=1.
REQ-035 shots preset near 16'hFFFF, two acked launches -> shots=16'hFFFF.
